// File: rtl/sv_uart_pkg.sv
// sv_uart_pkg
// Shared types and helpers for the UART transmit-side arbitration blocks.
//   arb_state_t       : arbiter FSM state encoding
//   SYNC_BYTE_DEFAULT : marker byte placed in the MSB of every header word
//   build_header()    : 16-bit header prefix {sync byte, source index}
package sv_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HDR  = 2'd2,
        ST_DATA = 2'd3
    } arb_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Upper 16 bits of a header word; the caller zero-fills the remainder.
    function automatic logic [15:0] build_header(input logic [7:0] sync_byte,
                                                 input logic [7:0] idx);
        return {sync_byte, idx};
    endfunction

endpackage

// File: rtl/sv_uart_tx_arbiter_if.sv
// sv_uart_tx_arbiter_if
// Bundles the requester-side and engine-side AXI-stream signals of the
// transmit arbiter.
//   s_axis_* : NUM_REQ packed requester streams (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   m_axis_* : single merged stream towards the UART engine
// Modports: master = the arbiter, slave = requesters plus engine.
interface sv_uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]            s_axis_tvalid;
    logic [NUM_REQ-1:0]            s_axis_tlast;
    logic [NUM_REQ-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/sv_uart_rr_arb.sv
// sv_uart_rr_arb
// Combinational round-robin picker: the first set bit of req found when
// scanning ptr, ptr+1, ... modulo NUM_REQ.
//   req   : request vector
//   ptr   : index with highest priority this round
//   gnt   : one-hot winner (0 when nothing requested)
//   idx   : binary index of the winner
//   valid : some request was found
module sv_uart_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);
    localparam int IDX_W = $clog2(NUM_REQ);

    // Rotating scan; modulo done by compare-and-subtract so any NUM_REQ works.
    always_comb begin
        int  sum;
        int  pos;
        logic hit;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum      = int'(ptr) + i;
            pos      = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
            hit      = !valid && req[pos];
            gnt[pos] = gnt[pos] | hit;
            idx      = hit ? IDX_W'(pos) : idx;
            valid    = valid | hit;
        end
    end
endmodule

// File: rtl/sv_uart_tx_arbiter.sv
// sv_uart_tx_arbiter
// Packet-granular round-robin arbiter sharing one UART transmit engine
// between NUM_REQ AXI-stream sources; optionally prefixes each grant with a
// header word {SYNC_BYTE, source index, zeros}.
//   iclk, irst : clock, asynchronous active-high reset
//   bus        : requester and engine streams (master modport)
//   ogrant     : one-hot current grant, 0 when idle
//   obusy      : FSM is outside IDLE
module sv_uart_tx_arbiter
    import sv_uart_pkg::*;
#(
    parameter int         DATA_WIDTH = 24,
    parameter int         NUM_REQ    = 4,
    parameter int         MAX_BURST  = 16,
    parameter int         HEADER_EN  = 1,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                      iclk,
    input  logic                      irst,
    sv_uart_tx_arbiter_if.master      bus,
    output logic [NUM_REQ-1:0]        ogrant,
    output logic                      obusy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t            state_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [NUM_REQ-1:0]    grant_r;
    logic [IDX_W-1:0]      grant_idx_r;
    logic [CNT_W-1:0]      burst_cnt_r;
    logic [DATA_WIDTH-1:0] hdr_data_r;

    logic [NUM_REQ-1:0]    arb_gnt_s;
    logic [IDX_W-1:0]      arb_idx_s;
    logic                  arb_valid_s;
    logic [DATA_WIDTH-1:0] header_word_s;
    logic                  sel_valid_s;
    logic                  data_hs_s;
    logic                  grant_end_s;

    sv_uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req   (bus.s_axis_tvalid),
        .ptr   (rr_ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    // Header for the requester about to be granted, captured in ARB.
    always_comb begin
        header_word_s = '0;
        header_word_s[DATA_WIDTH-1 -: 16] = build_header(SYNC_BYTE, 8'(arb_idx_s));
    end

    assign sel_valid_s = bus.s_axis_tvalid[grant_idx_r];
    assign data_hs_s   = (state_r == ST_DATA) && sel_valid_s && bus.m_axis_tready;
    // Grant closes on end of packet or on the word that fills the burst.
    assign grant_end_s = bus.s_axis_tlast[grant_idx_r] ||
                         (burst_cnt_r == CNT_W'(MAX_BURST - 1));

    // Arbiter FSM with grant, pointer and burst bookkeeping.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            grant_r     <= '0;
            grant_idx_r <= '0;
            burst_cnt_r <= '0;
            hdr_data_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= (|bus.s_axis_tvalid) ? ST_ARB : ST_IDLE;
                end
                ST_ARB: begin
                    if (arb_valid_s) begin
                        grant_r     <= arb_gnt_s;
                        grant_idx_r <= arb_idx_s;
                        hdr_data_r  <= header_word_s;
                        burst_cnt_r <= '0;
                        state_r     <= (HEADER_EN != 0) ? ST_HDR : ST_DATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HDR: begin
                    state_r <= bus.m_axis_tready ? ST_DATA : ST_HDR;
                end
                ST_DATA: begin
                    if (data_hs_s) begin
                        if (grant_end_s) begin
                            rr_ptr_r    <= (grant_idx_r == IDX_W'(NUM_REQ - 1)) ?
                                           '0 : grant_idx_r + IDX_W'(1);
                            burst_cnt_r <= '0;
                            grant_r     <= '0;
                            state_r     <= ST_IDLE;
                        end else begin
                            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Engine-side mux: held header in HDR, granted requester passed through in DATA.
    always_comb begin
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = '0;
        bus.s_axis_tready = '0;
        case (state_r)
            ST_HDR: begin
                bus.m_axis_tvalid = 1'b1;
                bus.m_axis_tdata  = hdr_data_r;
            end
            ST_DATA: begin
                bus.m_axis_tvalid = sel_valid_s;
                bus.m_axis_tdata  = bus.s_axis_tdata[int'(grant_idx_r)*DATA_WIDTH +: DATA_WIDTH];
                bus.s_axis_tready = grant_r & {NUM_REQ{bus.m_axis_tready}};
            end
            default: begin
                bus.m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign ogrant = grant_r;
    assign obusy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sv_uart_tx_arbiter.sv
// tb_sv_uart_tx_arbiter
// Self-checking bench: per-requester source queues feed the arbiter, the
// expected engine-side word sequence (data plus grant) is queued by each
// scenario and compared as words are accepted by the engine model.
module tb_sv_uart_tx_arbiter;
    localparam int DW = 24;
    localparam int NR = 4;
    localparam int MB = 16;

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [DW-1:0] data; logic [NR-1:0] grant; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sv_uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();
    logic [NR-1:0] ogrant;
    logic          obusy;

    sv_uart_tx_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .HEADER_EN(1), .SYNC_BYTE(8'hA5)
    ) dut (
        .iclk(clk), .irst(rst), .bus(bus), .ogrant(ogrant), .obusy(obusy)
    );

    beat_t         src_q[NR][$];
    exp_t          sb[$];
    logic [NR-1:0] pause     = '0;
    logic          eng_ready = 1'b0;
    logic [NR-1:0] hs;
    int            tests_run    = 0;
    int            tests_failed = 0;

    // Source/engine model: observe handshakes at negedge, advance at posedge+1.
    initial begin
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        hs = '0;
        forever begin
            @(negedge clk);
            hs = rst ? '0 : (bus.s_axis_tvalid & bus.s_axis_tready);
            if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_word: got %h, expected no word", bus.m_axis_tdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.m_axis_tdata !== e.data) begin
                        tests_failed++;
                        $display("FAIL word_data: got %h, expected %h", bus.m_axis_tdata, e.data);
                    end
                    tests_run++;
                    if (ogrant !== e.grant) begin
                        tests_failed++;
                        $display("FAIL word_grant: got %b, expected %b", ogrant, e.grant);
                    end
                end
                tests_run++;
                if ((bus.s_axis_tready & ~ogrant) !== '0) begin
                    tests_failed++;
                    $display("FAIL ready_onehot: got tready %b with grant %b", bus.s_axis_tready, ogrant);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && src_q[i].size() > 0) src_q[i].delete(0);
                bus.s_axis_tvalid[i]        = (src_q[i].size() > 0) && !pause[i];
                bus.s_axis_tdata[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0].data : '0;
                bus.s_axis_tlast[i]         = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
            end
            bus.m_axis_tready = eng_ready;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input int r, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[r].push_back(b);
    endtask

    task automatic expect_word(input int r, input logic [DW-1:0] d);
        exp_t e;
        logic [NR-1:0] one;
        one     = 4'b0001;
        e.data  = d;
        e.grant = one << r;
        sb.push_back(e);
    endtask

    task automatic expect_hdr(input int r);
        expect_word(r, {8'hA5, 8'(r), 8'h00});
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || !srcs_empty() || obusy) && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL %s_timeout: %0d words still expected, busy=%b", name, sb.size(), obusy);
        end
        tests_run++;
        if (ogrant !== '0 || obusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: got grant %b busy %b, expected 0 0", name, ogrant, obusy);
        end
    endtask

    task automatic wait_sb(input string name, input int left, input int budget);
        int n;
        n = 0;
        while (sb.size() > left && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= budget) begin
            tests_failed++;
            $display("FAIL %s_progress: got %0d words pending, expected <= %0d", name, sb.size(), left);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests_run++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== '0 || bus.s_axis_tready !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: got v=%b d=%h r=%b, expected 0 0 0",
                     bus.m_axis_tvalid, bus.m_axis_tdata, bus.s_axis_tready);
        end
        tests_run++;
        if (ogrant !== '0 || obusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got grant %b busy %b, expected 0 0", ogrant, obusy);
        end
        rst = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (obusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_busy: got %b, expected 0", obusy);
        end
    endtask

    task automatic test_single();
        eng_ready = 1'b1;
        expect_hdr(0);
        expect_word(0, 24'h111111);
        expect_word(0, 24'h222222);
        send_word(0, 24'h111111, 1'b0);
        send_word(0, 24'h222222, 1'b1);
        wait_idle("single", 100);
    endtask

    task automatic test_simultaneous();
        expect_hdr(1); expect_word(1, 24'h10AAAA);
        expect_hdr(3); expect_word(3, 24'h30BBBB);
        send_word(1, 24'h10AAAA, 1'b1);
        send_word(3, 24'h30BBBB, 1'b1);
        wait_idle("simul_1_3", 100);
        // Pointer wrapped to 0, so requester 0 must beat requester 1.
        expect_hdr(0); expect_word(0, 24'h01CCCC);
        expect_hdr(1); expect_word(1, 24'h11DDDD);
        send_word(0, 24'h01CCCC, 1'b1);
        send_word(1, 24'h11DDDD, 1'b1);
        wait_idle("simul_wrap", 100);
    endtask

    task automatic test_burst_limit();
        int n;
        expect_hdr(2);
        for (int k = 0; k < MB; k++) expect_word(2, 24'h200000 + DW'(k));
        expect_hdr(0);
        expect_word(0, 24'h0C0001);
        expect_word(0, 24'h0C0002);
        expect_hdr(2);
        for (int k = MB; k < 20; k++) expect_word(2, 24'h200000 + DW'(k));
        for (int k = 0; k < 20; k++) send_word(2, 24'h200000 + DW'(k), (k == 19));
        n = 0;
        while (ogrant !== 4'b0100 && n < 50) begin tick(); n++; end
        tests_run++;
        if (n >= 50) begin
            tests_failed++;
            $display("FAIL burst_grant2: got %b, expected 0100", ogrant);
        end
        send_word(0, 24'h0C0001, 1'b0);
        send_word(0, 24'h0C0002, 1'b1);
        wait_idle("burst", 400);
    endtask

    task automatic test_stall();
        int n;
        eng_ready = 1'b0;
        expect_hdr(1);
        for (int k = 0; k < 3; k++) expect_word(1, 24'h1A0000 + DW'(k));
        for (int k = 0; k < 3; k++) send_word(1, 24'h1A0000 + DW'(k), (k == 2));
        n = 0;
        while (bus.m_axis_tvalid !== 1'b1 && n < 50) begin tick(); n++; end
        for (int c = 0; c < 50; c++) begin
            tick();
            tests_run++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 24'hA50100 || bus.s_axis_tready !== '0) begin
                tests_failed++;
                $display("FAIL stall_hdr: cycle %0d got v=%b d=%h r=%b, expected 1 a50100 0",
                         c, bus.m_axis_tvalid, bus.m_axis_tdata, bus.s_axis_tready);
            end
        end
        eng_ready = 1'b1;
        wait_sb("stall", 2, 50);
        eng_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            tests_run++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 24'h1A0001 || bus.s_axis_tready !== '0) begin
                tests_failed++;
                $display("FAIL stall_data: cycle %0d got v=%b d=%h r=%b, expected 1 1a0001 0",
                         c, bus.m_axis_tvalid, bus.m_axis_tdata, bus.s_axis_tready);
            end
        end
        eng_ready = 1'b1;
        wait_idle("stall", 100);
    endtask

    task automatic test_pause();
        expect_hdr(2);
        for (int k = 0; k < 4; k++) expect_word(2, 24'h2C0000 + DW'(k));
        expect_hdr(3); expect_word(3, 24'h3D0000);
        expect_hdr(0); expect_word(0, 24'h0D0000);
        for (int k = 0; k < 4; k++) send_word(2, 24'h2C0000 + DW'(k), (k == 3));
        wait_sb("pause", 7, 50);
        pause[2] = 1'b1;
        send_word(3, 24'h3D0000, 1'b1);
        send_word(0, 24'h0D0000, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if (ogrant !== 4'b0100 || bus.m_axis_tvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL pause_hold: cycle %0d got grant %b valid %b, expected 0100 0",
                         c, ogrant, bus.m_axis_tvalid);
            end
        end
        pause[2] = 1'b0;
        wait_idle("pause", 100);
    endtask

    task automatic test_reset_mid();
        expect_hdr(3);
        for (int k = 0; k < 6; k++) expect_word(3, 24'h3E0000 + DW'(k));
        for (int k = 0; k < 6; k++) send_word(3, 24'h3E0000 + DW'(k), (k == 5));
        wait_sb("rst_mid", 4, 50);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.m_axis_tvalid !== 1'b0 || ogrant !== '0 || obusy !== 1'b0 || bus.s_axis_tready !== '0) begin
            tests_failed++;
            $display("FAIL rst_async: got v=%b grant=%b busy=%b r=%b, expected 0 0 0 0",
                     bus.m_axis_tvalid, ogrant, obusy, bus.s_axis_tready);
        end
        sb.delete();
        src_q[3].delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        // Pointer back at 0: requester 0 ahead of 2.
        expect_hdr(0); expect_word(0, 24'h0F0001);
        expect_hdr(2); expect_word(2, 24'h2F0001);
        send_word(0, 24'h0F0001, 1'b1);
        send_word(2, 24'h2F0001, 1'b1);
        wait_idle("rst_after", 100);
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_burst_limit();
        test_stall();
        test_pause();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
